// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one single-port data RAM between two masters
module dmem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WR, RD, RDW} state_t;

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t            state;
    logic              owner;
    logic              last;
    logic [1:0]        cnt;
    logic              winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // On a tie the master that did not win last time gets the RAM.
    always_comb begin
        winner = m1_req;
        if (m0_req && m1_req) begin
            winner = ~last;
        end
        sel_we    = winner ? m1_we    : m0_we;
        sel_addr  = winner ? m1_addr  : m0_addr;
        sel_wdata = winner ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            cnt       <= 2'd0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner     <= winner;
                        last      <= winner;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        m0_ack    <= ~winner;
                        m1_ack    <= winner;
                        busy      <= 1'b1;
                        if (sel_we) begin
                            mem_we <= 1'b1;
                            state  <= WR;
                        end else begin
                            state  <= RD;
                        end
                    end
                end
                WR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                RD: begin
                    cnt   <= CNT_INIT;
                    state <= RDW;
                end
                RDW: begin
                    // mem_addr stays put while the RAM pipeline drains.
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        if (owner) begin
                            m1_rdata  <= mem_rdata;
                            m1_rvalid <= 1'b1;
                        end else begin
                            m0_rdata  <= mem_rdata;
                            m0_rvalid <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter at read latencies 1 and 3
module tb_dmem_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic nRst;
    logic force_ff = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          m0_req, m0_we, m1_req, m1_we;
    logic [1:0]          m0_ack, m1_ack, m0_rvalid, m1_rvalid, mem_we, busy;
    logic [1:0][AW-1:0]  m0_addr, m1_addr, mem_addr;
    logic [1:0][DW-1:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
        return (a == 14'h3FFF) ? 32'h12345678 : {2'b10, a, 2'b01, a};
    endfunction

    // Instance 0 runs with RD_LAT=1, instance 1 with RD_LAT=3; each owns a RAM model.
    for (genvar g = 0; g < 2; g++) begin : g_env
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [DW-1:0] ram  [0:(1<<AW)-1];
        logic [DW-1:0] pipe [0:LAT-1];

        initial begin
            for (int a = 0; a < (1 << AW); a++) ram[a] = init_pat(14'(a));
        end

        always @(posedge clk) begin
            if (mem_we[g]) ram[mem_addr[g]] <= mem_wdata[g];
            pipe[0] <= ram[mem_addr[g]];
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end

        assign mem_rdata[g] = force_ff ? '1 : pipe[LAT-1];

        dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
            .clk(clk), .nRst(nRst),
            .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
            .m0_ack(m0_ack[g]), .m0_rdata(m0_rdata[g]), .m0_rvalid(m0_rvalid[g]),
            .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
            .m1_ack(m1_ack[g]), .m1_rdata(m1_rdata[g]), .m1_rvalid(m1_rvalid[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_we(mem_we[g]),
            .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        m0_req = '0; m0_we = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = '0; m1_we = '0; m1_addr = '0; m1_wdata = '0;
    endtask

    typedef struct {
        logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic [1:0] ack; logic [1:0] rv; logic we; logic bsy;
        logic [AW-1:0] ma; logic [DW-1:0] md; logic [DW-1:0] rd0; logic [DW-1:0] rd1;
    } vec_t;

    typedef struct { int at; int m; logic [DW-1:0] data; } rv_t;

    // Transaction-timeline model: a grant at edge n blocks the RAM until edge n+2 (write)
    // or n+lat+2 (read), and the read data appears lat+1 edges after the grant edge.
    task automatic run_random(input int d, input int lat, input int ncyc);
        logic [DW-1:0] mm [int];
        rv_t           pend [$];
        logic [DW-1:0] exp_rd [2];
        logic [AW-1:0] exp_ma;
        logic [DW-1:0] exp_md;
        int            free_edge;
        int            last_w;
        logic [1:0]    c_req, c_we, exp_ack, exp_rv;
        logic [AW-1:0] c_addr [2];
        logic [DW-1:0] c_wd   [2];
        logic          exp_we, exp_busy;
        int            win;
        nRst = 1'b0;
        clear_in();
        tick();
        nRst = 1'b1;
        free_edge = 0; last_w = 1; exp_ma = '0; exp_md = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        for (int n = 0; n < ncyc; n++) begin
            c_req = {m1_req[d], m0_req[d]};
            c_we  = {m1_we[d], m0_we[d]};
            c_addr[0] = m0_addr[d]; c_addr[1] = m1_addr[d];
            c_wd[0] = m0_wdata[d];  c_wd[1] = m1_wdata[d];
            tick();
            exp_ack = 2'b00; exp_we = 1'b0; exp_rv = 2'b00;
            if (n >= free_edge && c_req != 2'b00) begin
                win = (c_req == 2'b11) ? 1 - last_w : (c_req[1] ? 1 : 0);
                last_w = win;
                exp_ack[win] = 1'b1;
                exp_ma = c_addr[win];
                exp_md = c_wd[win];
                if (c_we[win]) begin
                    exp_we = 1'b1;
                    mm[int'(c_addr[win])] = c_wd[win];
                    free_edge = n + 2;
                end else begin
                    pend.push_back('{n + lat + 1, win,
                        mm.exists(int'(c_addr[win])) ? mm[int'(c_addr[win])] : init_pat(c_addr[win])});
                    free_edge = n + lat + 2;
                end
            end
            if (pend.size() > 0 && pend[0].at == n) begin
                exp_rv[pend[0].m] = 1'b1;
                exp_rd[pend[0].m] = pend[0].data;
                void'(pend.pop_front());
            end
            exp_busy = (n + 1 < free_edge);
            chk($sformatf("rnd%0d_c%0d_ctl", d, n),
                {m1_ack[d], m0_ack[d], m1_rvalid[d], m0_rvalid[d], mem_we[d], busy[d]},
                {exp_ack, exp_rv, exp_we, exp_busy});
            chk($sformatf("rnd%0d_c%0d_maddr", d, n), mem_addr[d], exp_ma);
            chk($sformatf("rnd%0d_c%0d_mwdata", d, n), mem_wdata[d], exp_md);
            chk($sformatf("rnd%0d_c%0d_rdata0", d, n), m0_rdata[d], exp_rd[0]);
            chk($sformatf("rnd%0d_c%0d_rdata1", d, n), m1_rdata[d], exp_rd[1]);
            // Requesters: hold until ack, then drop or present the next one.
            for (int m = 0; m < 2; m++) begin
                logic seen, cur, nw;
                seen = (m == 0) ? m0_ack[d] : m1_ack[d];
                cur  = (m == 0) ? m0_req[d] : m1_req[d];
                nw   = cur;
                if (seen) nw = ($urandom_range(0, 1) == 1);
                else if (!cur) nw = ($urandom_range(0, 9) < 3);
                else if ($urandom_range(0, 19) == 0) nw = 1'b0;
                if (nw && (seen || !cur)) begin
                    if (m == 0) begin
                        m0_we[d] = $urandom_range(0, 1) == 1;
                        m0_addr[d] = 14'h1000 + 14'($urandom_range(0, 15));
                        m0_wdata[d] = $urandom;
                    end else begin
                        m1_we[d] = $urandom_range(0, 1) == 1;
                        m1_addr[d] = 14'h1000 + 14'($urandom_range(0, 15));
                        m1_wdata[d] = $urandom;
                    end
                end
                if (m == 0) m0_req[d] = nw; else m1_req[d] = nw;
            end
        end
    endtask

    vec_t vt [10];
    int   ord [$];
    int   nack [2];
    int   nrv [2];
    int   rv_at, bcnt, got;

    initial begin
        vt[0] = '{1,1,14'h0010,32'hDEADBEEF, 0,0,14'h0,32'h0, 2'b01,2'b00,1,1, 14'h0010,32'hDEADBEEF, 32'h0,32'h0};
        vt[1] = '{0,0,14'h0,32'h0, 0,0,14'h0,32'h0, 2'b00,2'b00,0,0, 14'h0010,32'hDEADBEEF, 32'h0,32'h0};
        vt[2] = '{0,0,14'h0,32'h0, 1,0,14'h3FFF,32'h0, 2'b10,2'b00,0,1, 14'h3FFF,32'h0, 32'h0,32'h0};
        vt[3] = '{0,0,14'h0,32'h0, 0,0,14'h0,32'h0, 2'b00,2'b00,0,1, 14'h3FFF,32'h0, 32'h0,32'h0};
        vt[4] = '{0,0,14'h0,32'h0, 0,0,14'h0,32'h0, 2'b00,2'b10,0,0, 14'h3FFF,32'h0, 32'h0,32'h12345678};
        vt[5] = '{0,0,14'h0,32'h0, 0,0,14'h0,32'h0, 2'b00,2'b00,0,0, 14'h3FFF,32'h0, 32'h0,32'h12345678};
        vt[6] = '{1,1,14'h0001,32'hAAAA0001, 1,1,14'h0002,32'hBBBB0002, 2'b01,2'b00,1,1, 14'h0001,32'hAAAA0001, 32'h0,32'h12345678};
        vt[7] = '{0,0,14'h0,32'h0, 1,1,14'h0002,32'hBBBB0002, 2'b00,2'b00,0,0, 14'h0001,32'hAAAA0001, 32'h0,32'h12345678};
        vt[8] = '{0,0,14'h0,32'h0, 1,1,14'h0002,32'hBBBB0002, 2'b10,2'b00,1,1, 14'h0002,32'hBBBB0002, 32'h0,32'h12345678};
        vt[9] = '{0,0,14'h0,32'h0, 0,0,14'h0,32'h0, 2'b00,2'b00,0,0, 14'h0002,32'hBBBB0002, 32'h0,32'h12345678};

        // Reset with both requests up and the RAM bus at all-ones.
        nRst = 1'b0;
        clear_in();
        force_ff = 1'b1;
        m0_req[0] = 1; m0_we[0] = 1; m0_addr[0] = 14'h0020; m0_wdata[0] = 32'h11111111;
        m1_req[0] = 1; m1_we[0] = 1; m1_addr[0] = 14'h0021; m1_wdata[0] = 32'h22222222;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset%0d_ctl", d),
                {m1_ack[d], m0_ack[d], m1_rvalid[d], m0_rvalid[d], mem_we[d], busy[d]}, 6'b0);
            chk($sformatf("reset%0d_maddr", d), mem_addr[d], 0);
            chk($sformatf("reset%0d_mwdata", d), mem_wdata[d], 0);
            chk($sformatf("reset%0d_rdata", d), {m1_rdata[d], m0_rdata[d]}, 0);
        end
        force_ff = 1'b0;
        nRst = 1'b1;
        tick();
        chk("reset_first_grant", {m1_ack[0], m0_ack[0]}, 2'b01);
        chk("reset_first_maddr", mem_addr[0], 14'h0020);
        m0_req[0] = 0;
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            tick();
            got = m1_ack[0];
        end
        chk("reset_second_grant_m1", got, 1);
        chk("reset_second_maddr", mem_addr[0], 14'h0021);
        m1_req[0] = 0;
        tick();

        // Directed vectors on the RD_LAT=1 instance.
        for (int i = 0; i < 10; i++) begin
            m0_req[0] = vt[i].r0; m0_we[0] = vt[i].w0; m0_addr[0] = vt[i].a0; m0_wdata[0] = vt[i].d0;
            m1_req[0] = vt[i].r1; m1_we[0] = vt[i].w1; m1_addr[0] = vt[i].a1; m1_wdata[0] = vt[i].d1;
            tick();
            chk($sformatf("vec%0d_ctl", i),
                {m1_ack[0], m0_ack[0], m1_rvalid[0], m0_rvalid[0], mem_we[0], busy[0]},
                {vt[i].ack, vt[i].rv, vt[i].we, vt[i].bsy});
            chk($sformatf("vec%0d_maddr", i), mem_addr[0], vt[i].ma);
            chk($sformatf("vec%0d_mwdata", i), mem_wdata[0], vt[i].md);
            chk($sformatf("vec%0d_rdata0", i), m0_rdata[0], vt[i].rd0);
            chk($sformatf("vec%0d_rdata1", i), m1_rdata[0], vt[i].rd1);
        end
        clear_in();

        // Contention: both masters keep three reads each queued.
        nack[0] = 0; nack[1] = 0; nrv[0] = 0; nrv[1] = 0;
        m0_req[0] = 1; m0_addr[0] = 14'h0100;
        m1_req[0] = 1; m1_addr[0] = 14'h0200;
        for (int cyc = 0; cyc < 60 && (nrv[0] + nrv[1]) < 6; cyc++) begin
            tick();
            if (m0_rvalid[0]) begin
                chk($sformatf("cont_m0_rd%0d", nrv[0]), m0_rdata[0], init_pat(14'(14'h0100 + nrv[0])));
                nrv[0]++;
            end
            if (m1_rvalid[0]) begin
                chk($sformatf("cont_m1_rd%0d", nrv[1]), m1_rdata[0], init_pat(14'(14'h0200 + nrv[1])));
                nrv[1]++;
            end
            if (m0_ack[0]) begin
                ord.push_back(0); nack[0]++;
                if (nack[0] == 3) m0_req[0] = 0; else m0_addr[0] = 14'(14'h0100 + nack[0]);
            end
            if (m1_ack[0]) begin
                ord.push_back(1); nack[1]++;
                if (nack[1] == 3) m1_req[0] = 0; else m1_addr[0] = 14'(14'h0200 + nack[1]);
            end
        end
        chk("cont_rvalid_count", nrv[0] * 16 + nrv[1], 3 * 16 + 3);
        chk("cont_grant_count", ord.size(), 6);
        for (int i = 0; i < ord.size(); i++) chk($sformatf("cont_order%0d", i), ord[i], i % 2);
        clear_in();

        // RD_LAT=3 read by m1.
        rv_at = -1; bcnt = 0;
        m1_req[1] = 1; m1_we[1] = 0; m1_addr[1] = 14'h3FFF;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 0) begin
                chk("lat3_ack", {m1_ack[1], m0_ack[1]}, 2'b10);
                m1_req[1] = 0;
            end
            if (busy[1]) bcnt++;
            if (m1_rvalid[1]) begin
                rv_at = k;
                chk("lat3_rdata", m1_rdata[1], 32'h12345678);
            end
            if (k <= 4) chk($sformatf("lat3_addr_hold%0d", k), mem_addr[1], 14'h3FFF);
        end
        chk("lat3_rvalid_cycle", rv_at, 4);
        chk("lat3_busy_cycles", bcnt, 4);
        chk("lat3_m0_rdata_untouched", m0_rdata[1], 0);

        // Reset in the middle of a RD_LAT=3 read.
        m0_req[1] = 1; m0_we[1] = 0; m0_addr[1] = 14'h0123;
        tick();
        chk("midrst_ack", {m1_ack[1], m0_ack[1]}, 2'b01);
        m0_req[1] = 0;
        repeat (2) tick();
        chk("midrst_in_rdw", busy[1], 1);
        nRst = 1'b0;
        #1;
        chk("midrst_async_ctl", {m1_ack[1], m0_ack[1], m1_rvalid[1], m0_rvalid[1], mem_we[1], busy[1]}, 6'b0);
        chk("midrst_async_maddr", mem_addr[1], 0);
        repeat (2) tick();
        nRst = 1'b1;
        got = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            got += m0_rvalid[1];
        end
        chk("midrst_no_rvalid", got, 0);
        m0_req[1] = 1; m0_we[1] = 1; m0_addr[1] = 14'h0050; m0_wdata[1] = 32'h5A5A5A5A;
        m1_req[1] = 1; m1_we[1] = 1; m1_addr[1] = 14'h0051; m1_wdata[1] = 32'hA5A5A5A5;
        tick();
        chk("midrst_tie_grant", {m1_ack[1], m0_ack[1]}, 2'b01);
        chk("midrst_tie_maddr", mem_addr[1], 14'h0050);
        clear_in();
        got = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            got += m1_ack[1];
        end
        chk("withdrawn_req_ignored", got, 0);

        run_random(0, 1, 300);
        run_random(1, 3, 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
